// File: rtl/count_request_scheduler_pkg.sv
// Shared constants for the two-requester up/down count scheduler:
// one-hot FSM encoding, default widths and direction/selector encodings.
package count_request_scheduler_pkg;

  localparam int WIDTH_DEF  = 2;
  localparam int STEP_W_DEF = 3;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Requester selector used for the winner and last-served registers
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    STEP = 3'b010,
    DONE = 3'b100
  } state_e;

endpackage

// File: rtl/count_request_scheduler_updown_step_counter.sv
// Shared Count register: moves one step per enabled cycle, wrapping
// modulo 2^WIDTH in either direction.
module updown_step_counter
  import count_request_scheduler_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  output logic [WIDTH-1:0] Count
);

  logic [WIDTH-1:0] count_r;

  // Count register; natural unsigned overflow gives the wrap
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (En) begin
      if (Dir == UP) begin
        count_r <= count_r + WIDTH'(1);
      end else begin
        count_r <= count_r - WIDTH'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign Count = count_r;

endmodule

// File: rtl/count_request_scheduler.sv
// Arbitrates two step-count requesters onto one shared up/down counter,
// alternating on ties and reporting grant, completion and busy status.
module count_request_scheduler
  import count_request_scheduler_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req_A,
  input  logic              Dir_A,
  input  logic [STEP_W-1:0] Steps_A,
  input  logic              Req_B,
  input  logic              Dir_B,
  input  logic [STEP_W-1:0] Steps_B,
  output logic              Grant_A,
  output logic              Grant_B,
  output logic              Done_A,
  output logic              Done_B,
  output logic              Busy,
  output logic [WIDTH-1:0]  Count
);

  state_e            state_r, state_nxt_s;
  logic              winner_r, winner_nxt_s;
  logic              last_r, last_nxt_s;
  logic              dir_r, dir_nxt_s;
  logic [STEP_W-1:0] rem_r, rem_nxt_s;
  logic              pick_b_s;
  logic [STEP_W-1:0] sel_steps_s;
  logic              in_service_s;
  logic              grant_a_nxt_s, grant_b_nxt_s;
  logic              done_a_nxt_s, done_b_nxt_s, busy_nxt_s;
  logic              grant_a_r, grant_b_r, done_a_r, done_b_r, busy_r;

  // State register and job context; last-served resets to B so A wins the first tie
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r  <= IDLE;
      winner_r <= SEL_A;
      last_r   <= SEL_B;
      dir_r    <= DOWN;
      rem_r    <= {STEP_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      winner_r <= winner_nxt_s;
      last_r   <= last_nxt_s;
      dir_r    <= dir_nxt_s;
      rem_r    <= rem_nxt_s;
    end
  end

  // Next-state, arbitration and remaining-step bookkeeping
  always_comb begin
    pick_b_s     = Req_B && (!Req_A || (last_r == SEL_A));
    sel_steps_s  = pick_b_s ? Steps_B : Steps_A;
    state_nxt_s  = state_r;
    winner_nxt_s = winner_r;
    last_nxt_s   = last_r;
    dir_nxt_s    = dir_r;
    rem_nxt_s    = rem_r;
    case (state_r)
      IDLE: begin
        if (Req_A || Req_B) begin
          winner_nxt_s = pick_b_s ? SEL_B : SEL_A;
          last_nxt_s   = pick_b_s ? SEL_B : SEL_A;
          dir_nxt_s    = pick_b_s ? Dir_B : Dir_A;
          rem_nxt_s    = sel_steps_s;
          state_nxt_s  = (sel_steps_s != {STEP_W{1'b0}}) ? STEP : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STEP: begin
        rem_nxt_s = rem_r - STEP_W'(1);
        if (rem_r == STEP_W'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = STEP;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so status flops line up with state_r
  always_comb begin
    in_service_s  = (state_nxt_s == STEP) || (state_nxt_s == DONE);
    grant_a_nxt_s = in_service_s && (winner_nxt_s == SEL_A);
    grant_b_nxt_s = in_service_s && (winner_nxt_s == SEL_B);
    done_a_nxt_s  = (state_nxt_s == DONE) && (winner_nxt_s == SEL_A);
    done_b_nxt_s  = (state_nxt_s == DONE) && (winner_nxt_s == SEL_B);
    busy_nxt_s    = (state_nxt_s != IDLE);
  end

  // Registered status outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      grant_a_r <= 1'b0;
      grant_b_r <= 1'b0;
      done_a_r  <= 1'b0;
      done_b_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      grant_a_r <= grant_a_nxt_s;
      grant_b_r <= grant_b_nxt_s;
      done_a_r  <= done_a_nxt_s;
      done_b_r  <= done_b_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign Grant_A = grant_a_r;
  assign Grant_B = grant_b_r;
  assign Done_A  = done_a_r;
  assign Done_B  = done_b_r;
  assign Busy    = busy_r;

  updown_step_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .Clock (Clock),
    .Reset (Reset),
    .En    (state_r == STEP),
    .Dir   (dir_r),
    .Count (Count)
  );

endmodule

// File: tb/tb_count_request_scheduler.sv
// Scoreboard bench: each job pushes its expected completion (winner, final
// Count, grant length); a negedge monitor pops and compares on every Done.
module tb_count_request_scheduler;

  localparam int WIDTH  = 2;
  localparam int STEP_W = 3;
  localparam int MASK   = (1 << WIDTH) - 1;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Req_A, Dir_A, Req_B, Dir_B;
  logic [STEP_W-1:0] Steps_A, Steps_B;
  logic              Grant_A, Grant_B, Done_A, Done_B, Busy;
  logic [WIDTH-1:0]  Count;

  typedef struct {
    bit is_b;
    int cnt;
    int len;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   glen      = 0;
  int   done_cnt  = 0;
  int   exp_count = 0;
  int   target;

  count_request_scheduler #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req_A   (Req_A),
    .Dir_A   (Dir_A),
    .Steps_A (Steps_A),
    .Req_B   (Req_B),
    .Dir_B   (Dir_B),
    .Steps_B (Steps_B),
    .Grant_A (Grant_A),
    .Grant_B (Grant_B),
    .Done_A  (Done_A),
    .Done_B  (Done_B),
    .Busy    (Busy),
    .Count   (Count)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_job(input bit is_b, input bit up, input int n);
    exp_t e;
    exp_count = up ? ((exp_count + n) & MASK) : ((exp_count - n) & MASK);
    e.is_b = is_b;
    e.cnt  = exp_count;
    e.len  = n + 1;
    sb.push_back(e);
  endtask

  // Monitor: grant exclusivity every cycle, scoreboard compare on each Done
  always @(negedge Clock) begin
    exp_t e;
    check_eq("grant_excl", {31'd0, Grant_A & Grant_B}, 32'd0);
    if (Grant_A || Grant_B) glen++;
    else glen = 0;
    if (Done_A || Done_B) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexp_done", {30'd0, Done_B, Done_A}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("done_who", {30'd0, Done_B, Done_A}, e.is_b ? 32'd2 : 32'd1);
        check_eq("done_grant", {30'd0, Grant_B, Grant_A}, e.is_b ? 32'd2 : 32'd1);
        check_eq("done_count", {30'd0, Count}, e.cnt);
        check_eq("grant_len", glen, e.len);
      end
    end
  end

  initial begin
    Reset = 1'b1; Req_A = 1'b1; Req_B = 1'b1;
    Dir_A = 1'b1; Dir_B = 1'b0; Steps_A = 3'd7; Steps_B = 3'd7;

    // Reset held two cycles with both requests high
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      check_eq("rst_count", {30'd0, Count}, 32'd0);
      check_eq("rst_grant", {30'd0, Grant_B, Grant_A}, 32'd0);
      check_eq("rst_done", {30'd0, Done_B, Done_A}, 32'd0);
      check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    end
    Reset = 1'b0; Req_A = 1'b0; Req_B = 1'b0;
    @(negedge Clock);
    check_eq("idle_busy", {31'd0, Busy}, 32'd0);

    // A alone, up 5 from 0; later input changes must be ignored
    Req_A = 1'b1; Dir_A = 1'b1; Steps_A = 3'd5;
    push_job(1'b0, 1'b1, 5);
    @(negedge Clock);
    Req_A = 1'b0; Dir_A = 1'b0; Steps_A = 3'd2;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge Clock);
      check_eq("a5_count", {30'd0, Count}, (k - 1) & MASK);
      check_eq("a5_grant", {30'd0, Grant_B, Grant_A}, 32'd1);
    end
    @(negedge Clock);
    check_eq("a5_after_grant", {31'd0, Grant_A}, 32'd0);
    check_eq("a5_hold", {30'd0, Count}, 32'd1);

    // Tie after reset: A up 2 first, then B down 3
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    exp_count = 0;
    Req_A = 1'b1; Dir_A = 1'b1; Steps_A = 3'd2;
    Req_B = 1'b1; Dir_B = 1'b0; Steps_B = 3'd3;
    push_job(1'b0, 1'b1, 2);
    push_job(1'b1, 1'b0, 3);
    @(negedge Clock);
    check_eq("tie_a_first", {30'd0, Grant_B, Grant_A}, 32'd1);
    Req_A = 1'b0; Dir_A = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock); #1;
      if (Grant_B) break;
    end
    check_eq("tie_b_served", {31'd0, Grant_B}, 32'd1);
    Req_B = 1'b0; Dir_B = 1'b1; Steps_B = 3'd6;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock); #1;
      if (!Busy) break;
    end
    check_eq("tie_end_idle", {31'd0, Busy}, 32'd0);

    // B with zero steps: single grant+done cycle, Count unchanged
    Req_B = 1'b1; Dir_B = 1'b1; Steps_B = 3'd0;
    push_job(1'b1, 1'b1, 0);
    @(negedge Clock);
    check_eq("b0_grant_done", {29'd0, Grant_B, Done_B, Busy}, 32'd7);
    check_eq("b0_count", {30'd0, Count}, 32'd3);
    Req_B = 1'b0;
    @(negedge Clock);
    check_eq("b0_idle", {30'd0, Grant_B, Busy}, 32'd0);

    // Reset on the 3rd STEP cycle of a 6-step job aborts it
    Req_A = 1'b1; Dir_A = 1'b1; Steps_A = 3'd6;
    @(negedge Clock);
    Req_A = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check_eq("abort_partial", {30'd0, Count}, (exp_count + 2) & MASK);
    check_eq("abort_busy_pre", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    exp_count = 0;
    check_eq("abort_busy", {31'd0, Busy}, 32'd0);
    check_eq("abort_grant", {30'd0, Grant_B, Grant_A}, 32'd0);
    check_eq("abort_done", {30'd0, Done_B, Done_A}, 32'd0);
    check_eq("abort_count", {30'd0, Count}, 32'd0);
    repeat (3) @(negedge Clock);

    // Both held high, 1 step each: completions alternate A, B, A, B
    Req_A = 1'b1; Dir_A = 1'b1; Steps_A = 3'd1;
    Req_B = 1'b1; Dir_B = 1'b0; Steps_B = 3'd1;
    push_job(1'b0, 1'b1, 1);
    push_job(1'b1, 1'b0, 1);
    push_job(1'b0, 1'b1, 1);
    push_job(1'b1, 1'b0, 1);
    target = done_cnt + 4;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock); #1;
      if (done_cnt >= target) break;
    end
    check_eq("alt_done_count", done_cnt, target);
    Req_A = 1'b0; Req_B = 1'b0;

    repeat (4) @(negedge Clock);
    check_eq("sb_empty", sb.size(), 32'd0);
    check_eq("final_idle", {31'd0, Busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
